lcd_timing_gen: RTL and testbench
=================================

// Module: lcd_timing_gen
// PURPOSE
// Consumes the divided PLL pixel clock (24 MHz in, x25/3 = 200 MHz VCO out, /6 = 33.33 MHz) and drives the RGB LCD.
// Generates HSYNC/VSYNC/DE timing for an 800x480 panel at about 60 Hz, plus pixel coordinates and a built-in RGB565 test pattern.
// Holds the panel idle for a startup interval after reset, because PLL lock is not exported to the fabric.
// PARAMETERS
// H_ACTIVE 800   visible pixels per line; must be a multiple of 8
// H_FP 210       horizontal front porch, in clocks
// H_SYNC 20      HSYNC pulse width, in clocks
// H_BP 26        horizontal back porch; H_TOTAL = 1056
// V_ACTIVE 480   visible lines per frame
// V_FP 22        vertical front porch, in lines
// V_SYNC 10      VSYNC pulse width, in lines
// V_BP 13        vertical back porch; V_TOTAL = 525
// STARTUP_CYCLES 1024  idle clocks after reset before timing starts (>=1)
// SYNC_ACTIVE_LOW 1    1: sync pulses drive 0; 0: sync pulses drive 1
// PORTS
// clk         in   1   pixel clock (PLL clkoutd)
// rst_n       in   1   synchronous active-low reset
// mode        in   2   pattern: 0 colour bars, 1 checker, 2 white, 3 black
// lcd_hsync   out  1   horizontal sync
// lcd_vsync   out  1   vertical sync
// lcd_de      out  1   data enable, high on visible pixels
// lcd_r       out  5   red
// lcd_g       out  6   green
// lcd_b       out  5   blue
// px_x        out  10  x of the current pixel; valid only while lcd_de=1
// px_y        out  10  y of the current pixel; valid only while lcd_de=1
// frame_start out  1   one-cycle pulse, coincident with pixel (0,0)
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state=WAIT; startup counter, h_cnt and v_cnt = 0.
//   Outputs: de=0, rgb=0, px_x=px_y=0, frame_start=0, syncs inactive (1 when SYNC_ACTIVE_LOW), mode latch=0.
// - WAIT: counter increments once per clk. On the edge where it reaches STARTUP_CYCLES: state<=RUN, h=v=0.
//   Outputs stay at their idle values throughout WAIT.
// - RUN: h_cnt increments each clk and wraps at H_TOTAL-1 to 0; v_cnt increments on each h wrap and wraps at V_TOTAL-1.
// - Segment order, both axes: active [0,ACT-1] -> FP -> SYNC -> BP. Horizontal sync is h in [1010,1029]; vertical sync is v in [502,511].
// - All outputs are registered: each output reflects the counters of the previous cycle (latency 1 clk).
//   The first lcd_de=1 and frame_start pulse occur on edge STARTUP_CYCLES+1 after rst_n is sampled high.
// - lcd_de = (h<H_ACTIVE)&&(v<V_ACTIVE). lcd_hsync follows h only, so HSYNC also toggles during vertical blanking.
// - lcd_vsync is asserted for whole lines, V_SYNC*H_TOTAL clocks, and changes only at h=0.
// - mode is sampled only when h=0 and v=0. A change mid-frame takes effect at the next frame_start, never within a frame.
// - rgb = 0 whenever lcd_de=0.
// - Bars: 8 bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black.
//   Each channel is all-ones or 0. The bar index comes from a width counter, not a divider.
// - Checker: white when px_x[5]^px_y[5]=1, else black.
// - Counters are exactly wide enough (11 bits h, 10 bits v); no overflow beyond the TOTAL-1 wrap.
// - rst_n low in RUN: idle outputs on the next edge, then a full STARTUP wait again. A partial line or frame is never resumed.
// TESTING
// - Startup: release rst_n -> de/frame_start=0 for edges 1..1024; de=1, frame_start=1, px=(0,0) at edge 1025.
// - Line timing: de high for 800 consecutive clks. HSYNC low for 20 clks starting 1010 clks after the de rise; line period 1056.
// - Frame timing: 480 lines with de, VSYNC low for 10560 clks, frame_start period 554400 clks.
// - Bars (mode=0): rgb at x=0 is 31/63/31; at x=100 is 31/63/0; at x=700 is 0/0/0; rgb=0 at h=800.
// - Mode 0->2 mid-frame: bars continue to the end of the frame; all visible pixels 31/63/31 from the next frame_start.
// - rst_n low at h=400 for 1 clk: next edge de=0 and syncs idle; de resumes exactly 1025 edges after rst_n returns high.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: HSYNC/VSYNC/DE timing for an RGB565 LCD panel, with a built-in
// test pattern. The panel is held idle for a startup interval after reset,
// because PLL lock is not available to the fabric.
// Handshake: none. The pixel stream is free-running. lcd_de qualifies lcd_r/g/b
// and px_x/px_y on every clock, and the panel samples them whenever lcd_de=1.
// The checker pattern uses bit 5 of both counters, so each axis needs at least
// 6 counter bits.
module lcd_timing_gen #(
  parameter int H_ACTIVE        = 800,
  parameter int H_FP            = 210,
  parameter int H_SYNC          = 20,
  parameter int H_BP            = 26,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 22,
  parameter int V_SYNC          = 10,
  parameter int V_BP            = 13,
  parameter int STARTUP_CYCLES  = 1024,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic       lcd_de,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = $clog2(STARTUP_CYCLES + 1);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0] SU_LAST  = SW'(STARTUP_CYCLES - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] su_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [BW-1:0] bar_w;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_q;

  logic       h_last, v_last, h_act, v_act, de_now;
  logic       hs_on, vs_on, at_origin;
  logic [1:0] mode_eff;
  logic [2:0] pix;

  // Decode the current counter position into timing segments.
  always_comb begin
    h_last    = (h_cnt == H_LAST);
    v_last    = (v_cnt == V_LAST);
    h_act     = (h_cnt < H_ACT_C);
    v_act     = (v_cnt < V_ACT_C);
    de_now    = h_act && v_act;
    hs_on     = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    vs_on     = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    // The new mode applies from pixel (0,0) itself, never mid-frame.
    mode_eff  = at_origin ? mode : mode_q;
  end

  // Select the pattern colour as one bit per channel (r,g,b).
  always_comb begin
    pix = 3'b000;
    case (mode_eff)
      2'd0:    pix = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
      2'd1:    pix = {3{h_cnt[5] ^ v_cnt[5]}};
      2'd2:    pix = 3'b111;
      default: pix = 3'b000;
    endcase
  end

  // Startup wait, raster counters, bar width counter and the mode latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_WAIT;
      su_cnt  <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_w   <= '0;
      bar_idx <= '0;
      mode_q  <= 2'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          su_cnt <= su_cnt + 1'b1;
          if (su_cnt == SU_LAST) begin
            state   <= ST_RUN;
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_w   <= '0;
            bar_idx <= '0;
          end
        end
        default: begin
          if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
          // Bar index tracks h by counting bar widths, restarting every line.
          if (h_last) begin
            bar_w   <= '0;
            bar_idx <= '0;
          end else if (h_act) begin
            if (bar_w == BAR_LAST) begin
              bar_w   <= '0;
              bar_idx <= bar_idx + 1'b1;
            end else begin
              bar_w <= bar_w + 1'b1;
            end
          end
          if (at_origin) mode_q <= mode;
        end
      endcase
    end
  end

  // Register all panel outputs from the current counters; idle outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n || state == ST_WAIT) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= SYNC_OFF;
      lcd_vsync   <= SYNC_OFF;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
    end else begin
      lcd_de      <= de_now;
      lcd_hsync   <= hs_on ? SYNC_ON : SYNC_OFF;
      lcd_vsync   <= vs_on ? SYNC_ON : SYNC_OFF;
      lcd_r       <= {5{pix[2] & de_now}};
      lcd_g       <= {6{pix[1] & de_now}};
      lcd_b       <= {5{pix[0] & de_now}};
      px_x        <= 10'(h_cnt);
      px_y        <= 10'(v_cnt);
      frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: a full-size instance for startup, line
// timing, bars and reset recovery, and a shrunken instance (active-high syncs)
// for whole-frame timing, mode latching and the checker pattern.
module tb_lcd_timing_gen;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_s_n;
  logic [1:0] mode, mode_s;

  logic       hsync, vsync, de, fs;
  logic [4:0] r, b;
  logic [5:0] g;
  logic [9:0] px_x, px_y;
  logic [15:0] rgb;
  assign rgb = {r, g, b};

  logic       hsync_s, vsync_s, de_s, fs_s;
  logic [4:0] r_s, b_s;
  logic [5:0] g_s;
  logic [9:0] px_x_s, px_y_s;
  logic [15:0] rgb_s;
  assign rgb_s = {r_s, g_s, b_s};

  lcd_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .lcd_hsync(hsync), .lcd_vsync(vsync), .lcd_de(de),
    .lcd_r(r), .lcd_g(g), .lcd_b(b),
    .px_x(px_x), .px_y(px_y), .frame_start(fs)
  );

  // 76 x 47 raster: H 64/4/4/4, V 40/2/3/2, frame = 3572 clocks.
  lcd_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .STARTUP_CYCLES(5), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_s_n), .mode(mode_s),
    .lcd_hsync(hsync_s), .lcd_vsync(vsync_s), .lcd_de(de_s),
    .lcd_r(r_s), .lcd_g(g_s), .lcd_b(b_s),
    .px_x(px_x_s), .px_y(px_y_s), .frame_start(fs_s)
  );

  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam int SF = 3572;

  int total = 0;
  int bad   = 0;

  int n_bad, de_cnt, last_de, hs_cnt, hs_first, vs_cnt, vs_first, fs_cnt, white_cnt, n;
  logic found;
  logic [15:0] rgb100, rgb700, rgb800, rgb_a, c0, c1, c2, c3;
  logic [9:0]  px100;

  // Driver: advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard comparison.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_s_n = 1'b0; mode = 2'd0; mode_s = 2'd0;
    step(); step();
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_px", {12'd0, px_x, px_y}, 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);
    chk("rst_s_syncs", {30'd0, hsync_s, vsync_s}, 32'd0);

    // Startup: edges 1..1024 idle, edge 1025 is pixel (0,0).
    rst_n = 1'b1;
    n_bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      step();
      if (de || fs || !hsync || !vsync || rgb != 16'd0) n_bad++;
    end
    chk("startup_idle", 32'(n_bad), 32'd0);
    step();
    chk("first_de", 32'(de), 32'd1);
    chk("first_fs", 32'(fs), 32'd1);
    chk("first_px", {12'd0, px_x, px_y}, 32'd0);
    chk("bar_x0", 32'(rgb), 32'(WHITE));

    // One full line.
    de_cnt = 0; last_de = -1; hs_cnt = 0; hs_first = -1;
    for (int k = 0; k < 1056; k++) begin
      if (de) begin de_cnt++; last_de = k; end
      if (!hsync) begin hs_cnt++; if (hs_first < 0) hs_first = k; end
      if (k == 100) begin rgb100 = rgb; px100 = px_x; end
      if (k == 700) rgb700 = rgb;
      if (k == 800) rgb800 = rgb;
      step();
    end
    chk("line_de_cnt", 32'(de_cnt), 32'd800);
    chk("line_de_last", 32'(last_de), 32'd799);
    chk("hsync_start", 32'(hs_first), 32'd1010);
    chk("hsync_width", 32'(hs_cnt), 32'd20);
    chk("bar_x100", 32'(rgb100), 32'(YELLOW));
    chk("px_x100", 32'(px100), 32'd100);
    chk("bar_x700", 32'(rgb700), 32'(BLACK));
    chk("rgb_h800", 32'(rgb800), 32'(BLACK));
    chk("line1_de", 32'(de), 32'd1);
    chk("line1_px", {12'd0, px_x, px_y}, {12'd0, 10'd0, 10'd1});
    chk("line1_fs", 32'(fs), 32'd0);

    // Reset pulse at h=400 of line 1.
    for (int i = 0; i < 400; i++) step();
    chk("pre_rst_px_x", 32'(px_x), 32'd400);
    rst_n = 1'b0;
    step();
    chk("mid_rst_de", 32'(de), 32'd0);
    chk("mid_rst_syncs", {30'd0, hsync, vsync}, 32'd3);
    chk("mid_rst_rgb", 32'(rgb), 32'd0);
    rst_n = 1'b1;
    n = 0; found = 1'b0;
    while (!found && n < 1200) begin
      step();
      n++;
      if (de) found = 1'b1;
    end
    chk("resume_edges", 32'(n), 32'd1025);
    chk("resume_fs", 32'(fs), 32'd1);

    // Small instance: startup of 5 edges.
    rst_s_n = 1'b1;
    n_bad = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (de_s || fs_s || hsync_s || vsync_s) n_bad++;
    end
    chk("s_startup_idle", 32'(n_bad), 32'd0);
    step();
    chk("s_first_de", 32'(de_s), 32'd1);
    chk("s_first_fs", 32'(fs_s), 32'd1);

    // Frame 1 in bars; mode goes to white mid-frame and must not show yet.
    de_cnt = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; fs_cnt = 0;
    for (int k = 0; k < SF; k++) begin
      if (de_s) de_cnt++;
      if (hsync_s) begin hs_cnt++; if (hs_first < 0) hs_first = k; end
      if (vsync_s) begin vs_cnt++; if (vs_first < 0) vs_first = k; end
      if (fs_s) fs_cnt++;
      if (k == 5 * 76 + 8) rgb_a = rgb_s;
      if (k == 100) mode_s = 2'd2;
      step();
    end
    chk("s_frame_de", 32'(de_cnt), 32'd2560);
    chk("s_hsync_first", 32'(hs_first), 32'd68);
    chk("s_hsync_cnt", 32'(hs_cnt), 32'd188);
    chk("s_vsync_first", 32'(vs_first), 32'd3192);
    chk("s_vsync_cnt", 32'(vs_cnt), 32'd228);
    chk("s_fs_cnt", 32'(fs_cnt), 32'd1);
    chk("s_bars_kept", 32'(rgb_a), 32'(YELLOW));
    chk("s_fs_period", 32'(fs_s), 32'd1);

    // Frame 2 all white; switch to checker mid-frame.
    white_cnt = 0;
    for (int k = 0; k < SF; k++) begin
      if (de_s && rgb_s == WHITE) white_cnt++;
      if (k == 500) mode_s = 2'd1;
      step();
    end
    chk("s_white_frame", 32'(white_cnt), 32'd2560);

    // Frame 3 checker.
    white_cnt = 0;
    for (int k = 0; k < SF; k++) begin
      if (de_s && rgb_s == WHITE) white_cnt++;
      if (k == 32) c0 = rgb_s;
      if (k == 32 * 76) c1 = rgb_s;
      if (k == 32 * 76 + 32) c2 = rgb_s;
      if (k == 76 + 5) c3 = rgb_s;
      step();
    end
    chk("s_chk_32_0", 32'(c0), 32'(WHITE));
    chk("s_chk_0_32", 32'(c1), 32'(WHITE));
    chk("s_chk_32_32", 32'(c2), 32'(BLACK));
    chk("s_chk_5_1", 32'(c3), 32'(BLACK));
    chk("s_chk_whites", 32'(white_cnt), 32'd1280);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
